// File: rtl/dmem_arb.sv
// Two-master arbiter and access sequencer for the 4 KiB data memory.
// Round-robin arbitration with bounded locking, misalignment rejection, load extension.
module dmem_arb #(
  parameter int LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [11:0] m0_addr,
  input  logic [1:0]  m0_size,
  input  logic        m0_uns,
  input  logic        m0_lock,
  input  logic [63:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic        m0_err,
  output logic [63:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [11:0] m1_addr,
  input  logic [1:0]  m1_size,
  input  logic        m1_uns,
  input  logic        m1_lock,
  input  logic [63:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic        m1_err,
  output logic [63:0] m1_rdata,
  output logic        mem_cs,
  output logic        mem_rw,
  output logic [11:0] mem_addr,
  output logic [1:0]  mem_word,
  output logic [63:0] mem_dataw,
  input  logic [63:0] mem_datar
);

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

  logic        last_gnt;
  logic        lock_hold;
  logic [3:0]  lock_cnt;

  logic        any_req;
  logic        win;
  logic        other_req;
  logic        sel_we;
  logic [11:0] sel_addr;
  logic [1:0]  sel_size;
  logic        sel_uns;
  logic        sel_lock;
  logic [63:0] sel_wdata;
  logic        misaligned;
  logic [63:0] ext_data;

  // Winner selection; with no request the mux defaults to master 0's fields.
  always_comb begin
    any_req = m0_req | m1_req;
    win     = m1_req;
    if (m0_req && m1_req) begin
      win = (lock_hold && (lock_cnt < LOCK_LIM)) ? last_gnt : ~last_gnt;
    end
    other_req = win ? m0_req : m1_req;
    m0_gnt    = any_req & ~win;
    m1_gnt    = any_req & win;
    sel_we    = win ? m1_we    : m0_we;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_size  = win ? m1_size  : m0_size;
    sel_uns   = win ? m1_uns   : m0_uns;
    sel_lock  = win ? m1_lock  : m0_lock;
    sel_wdata = win ? m1_wdata : m0_wdata;
  end

  always_comb begin
    misaligned = 1'b0;
    case (sel_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = sel_addr[0];
      2'd2:    misaligned = |sel_addr[1:0];
      default: misaligned = |sel_addr[2:0];
    endcase
    mem_cs    = any_req & ~misaligned;
    mem_rw    = mem_cs & sel_we;
    mem_addr  = sel_addr;
    mem_word  = sel_size;
    mem_dataw = sel_wdata;
  end

  always_comb begin
    ext_data = mem_datar;
    case (sel_size)
      2'd0:    ext_data = {{56{~sel_uns & mem_datar[7]}},  mem_datar[7:0]};
      2'd1:    ext_data = {{48{~sel_uns & mem_datar[15]}}, mem_datar[15:0]};
      2'd2:    ext_data = {{32{~sel_uns & mem_datar[31]}}, mem_datar[31:0]};
      default: ext_data = mem_datar;
    endcase
  end

  // Lock bookkeeping: the streak only grows while the other master is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt  <= 1'b1;
      lock_hold <= 1'b0;
      lock_cnt  <= 4'd0;
    end else if (any_req) begin
      last_gnt  <= win;
      lock_hold <= sel_lock;
      if (!sel_lock || (win != last_gnt)) begin
        lock_cnt <= 4'd0;
      end else if (lock_hold && other_req && (lock_cnt < LOCK_LIM)) begin
        lock_cnt <= lock_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt;
      m0_err    <= m0_gnt & misaligned;
      m0_rdata  <= (m0_gnt && !misaligned && !sel_we) ? ext_data : '0;
      m1_rvalid <= m1_gnt;
      m1_err    <= m1_gnt & misaligned;
      m1_rdata  <= (m1_gnt && !misaligned && !sel_we) ? ext_data : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: directed scenarios plus random traffic against a
// transaction-level model of arbitration, memory contents and load extension.
module tb_dmem_arb;

  localparam int LOCK_MAX = 4;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m0_uns, m0_lock, m0_gnt, m0_rvalid, m0_err;
  logic [11:0] m0_addr;
  logic [1:0]  m0_size;
  logic [63:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_uns, m1_lock, m1_gnt, m1_rvalid, m1_err;
  logic [11:0] m1_addr;
  logic [1:0]  m1_size;
  logic [63:0] m1_wdata, m1_rdata;
  logic        mem_cs, mem_rw;
  logic [11:0] mem_addr;
  logic [1:0]  mem_word;
  logic [63:0] mem_dataw, mem_datar;

  dmem_arb #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size),
    .m0_uns(m0_uns), .m0_lock(m0_lock), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_uns(m1_uns), .m1_lock(m1_lock), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_word(mem_word),
    .mem_dataw(mem_dataw), .mem_datar(mem_datar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Memory driven by the DUT's outputs, and the model's own view of the contents.
  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];

  int          last_m;
  bit          hold;
  int          cnt;
  bit          exp_rv  [2];
  bit          exp_err [2];
  logic [63:0] exp_rd  [2];
  int          model_win;
  int          gnt_seen;
  bit          cs_seen;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit misaligned(input int addr, input int size);
    return (addr % (1 << size)) != 0;
  endfunction

  function automatic logic [63:0] load_ref(input int addr, input int size, input bit uns);
    int n;
    logic [63:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[(addr + i) % 4096]) << (8 * i));
    if (!uns && n < 8 && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  task automatic model_reset();
    last_m = 1;
    hold   = 0;
    cnt    = 0;
    for (int m = 0; m < 2; m++) begin
      exp_rv[m]  = 0;
      exp_err[m] = 0;
      exp_rd[m]  = '0;
    end
  endtask

  task automatic set_m0(input bit req, input bit we, input logic [11:0] addr, input logic [1:0] size,
                        input bit uns, input bit lock, input logic [63:0] wdata);
    m0_req = req; m0_we = we; m0_addr = addr; m0_size = size;
    m0_uns = uns; m0_lock = lock; m0_wdata = wdata;
  endtask

  task automatic set_m1(input bit req, input bit we, input logic [11:0] addr, input logic [1:0] size,
                        input bit uns, input bit lock, input logic [63:0] wdata);
    m1_req = req; m1_we = we; m1_addr = addr; m1_size = size;
    m1_uns = uns; m1_lock = lock; m1_wdata = wdata;
  endtask

  // One clock cycle: check grant-cycle outputs and pending responses, then advance the model.
  task automatic apply_stimulus();
    bit r[2], we[2], uns[2], lk[2];
    int addr[2], size[2];
    logic [63:0] wd[2];
    int win, sel;
    bit exp_cs, mis;
    bit w_do;
    int w_addr, w_word;
    logic [63:0] w_data;
    r[0] = m0_req; we[0] = m0_we; uns[0] = m0_uns; lk[0] = m0_lock;
    addr[0] = int'(m0_addr); size[0] = int'(m0_size); wd[0] = m0_wdata;
    r[1] = m1_req; we[1] = m1_we; uns[1] = m1_uns; lk[1] = m1_lock;
    addr[1] = int'(m1_addr); size[1] = int'(m1_size); wd[1] = m1_wdata;
    #1;
    for (int i = 0; i < 8; i++) mem_datar[8 * i +: 8] = mem[(int'(mem_addr) + i) % 4096];
    #2;
    win = -1;
    if (r[0] && r[1]) win = (hold && cnt < LOCK_MAX) ? last_m : 1 - last_m;
    else if (r[0]) win = 0;
    else if (r[1]) win = 1;
    sel = (win < 0) ? 0 : win;
    mis = misaligned(addr[sel], size[sel]);
    exp_cs = (win >= 0) && !mis;
    check_output("m0_gnt", m0_gnt, win == 0);
    check_output("m1_gnt", m1_gnt, win == 1);
    check_output("mem_cs", mem_cs, exp_cs);
    check_output("mem_rw", mem_rw, exp_cs && we[sel]);
    check_output("mem_addr", mem_addr, 64'(addr[sel]));
    check_output("mem_word", mem_word, 64'(size[sel]));
    check_output("mem_dataw", mem_dataw, wd[sel]);
    check_output("m0_rvalid", m0_rvalid, exp_rv[0]);
    check_output("m0_err", m0_err, exp_err[0]);
    check_output("m0_rdata", m0_rdata, exp_rd[0]);
    check_output("m1_rvalid", m1_rvalid, exp_rv[1]);
    check_output("m1_err", m1_err, exp_err[1]);
    check_output("m1_rdata", m1_rdata, exp_rd[1]);
    gnt_seen = m1_gnt ? 1 : (m0_gnt ? 0 : -1);
    cs_seen  = mem_cs;
    w_do   = mem_cs && mem_rw;
    w_addr = int'(mem_addr);
    w_word = int'(mem_word);
    w_data = mem_dataw;
    @(posedge clk);
    if (w_do) begin
      for (int i = 0; i < (1 << w_word); i++) mem[(w_addr + i) % 4096] = w_data[8 * i +: 8];
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      exp_rv[m] = 0; exp_err[m] = 0; exp_rd[m] = '0;
    end
    model_win = win;
    if (win >= 0) begin
      exp_rv[win]  = 1;
      exp_err[win] = mis;
      if (!mis && !we[win]) exp_rd[win] = load_ref(addr[win], size[win], uns[win]);
      if (!mis && we[win]) begin
        for (int i = 0; i < (1 << size[win]); i++)
          ref_mem[(addr[win] + i) % 4096] = wd[win][8 * i +: 8];
      end
      if (!lk[win] || win != last_m) cnt = 0;
      else if (hold && r[1 - win] && cnt < LOCK_MAX) cnt = cnt + 1;
      hold   = lk[win];
      last_m = win;
    end
  endtask

  task automatic do_reset();
    set_m0(0, 0, 12'h0, 2'd0, 0, 0, 64'h0);
    set_m1(0, 0, 12'h0, 2'd0, 0, 0, 64'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_fields(output bit we, output logic [11:0] addr, output logic [1:0] size,
                             output bit uns, output bit lock, output logic [63:0] wdata);
    int sz;
    int a;
    sz = $urandom_range(0, 3);
    a  = $urandom_range(0, 255);
    if ($urandom_range(0, 5) != 0) a = a - (a % (1 << sz));
    size  = 2'(sz);
    addr  = 12'(a);
    we    = 1'($urandom_range(0, 1));
    uns   = 1'($urandom_range(0, 1));
    lock  = ($urandom_range(0, 2) != 0);
    wdata = {$urandom, $urandom};
  endtask

  logic [11:0] ext_addr [4];
  logic [1:0]  ext_size [4];
  bit          ext_uns  [4];
  logic [63:0] ext_exp  [4];
  int          lk_pat   [8];

  initial begin
    bit we, uns, lock;
    logic [11:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem_datar = '0;
    set_m0(0, 0, 12'h0, 2'd0, 0, 0, 64'h0);
    set_m1(0, 0, 12'h0, 2'd0, 0, 0, 64'h0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_m0_rvalid", m0_rvalid, 1'b0);
    check_output("rst_m0_err", m0_err, 1'b0);
    check_output("rst_m0_rdata", m0_rdata, 64'h0);
    check_output("rst_m1_rvalid", m1_rvalid, 1'b0);
    check_output("rst_m1_err", m1_err, 1'b0);
    check_output("rst_m1_rdata", m1_rdata, 64'h0);
    rst_n = 1'b1;
    model_reset();

    // Single master dword write then read back.
    set_m0(1, 1, 12'h010, 2'd3, 0, 0, 64'h1122334455667788);
    apply_stimulus();
    check_output("wr_gnt", 64'(gnt_seen), 64'd0);
    set_m0(1, 0, 12'h010, 2'd3, 0, 0, 64'h0);
    apply_stimulus();
    check_output("rd_gnt", 64'(gnt_seen), 64'd0);
    check_output("rd_rvalid", m0_rvalid, 1'b1);
    check_output("rd_err", m0_err, 1'b0);
    check_output("rd_rdata", m0_rdata, 64'h1122334455667788);

    // Load extension cases.
    ext_addr = '{12'h010, 12'h010, 12'h017, 12'h016};
    ext_size = '{2'd0, 2'd0, 2'd0, 2'd1};
    ext_uns  = '{0, 1, 0, 0};
    ext_exp  = '{64'hFFFFFFFFFFFFFF88, 64'h88, 64'h11, 64'h1122};
    for (int k = 0; k < 4; k++) begin
      set_m0(1, 0, ext_addr[k], ext_size[k], ext_uns[k], 0, 64'h0);
      apply_stimulus();
      check_output($sformatf("ext_%0d", k), m0_rdata, ext_exp[k]);
    end
    set_m0(0, 0, 12'h0, 2'd0, 0, 0, 64'h0);
    apply_stimulus();

    // Round-robin with no lock.
    do_reset();
    set_m0(1, 0, 12'h020, 2'd2, 1, 0, 64'h0);
    set_m1(1, 0, 12'h028, 2'd3, 0, 0, 64'h0);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus();
      check_output($sformatf("rr_gnt_%0d", k), 64'(gnt_seen), 64'(k % 2));
      check_output($sformatf("rr_m0_rv_%0d", k), m0_rvalid, (k % 2) == 0);
      check_output($sformatf("rr_m1_rv_%0d", k), m1_rvalid, (k % 2) == 1);
    end

    // Bounded lock held by master 1.
    do_reset();
    set_m0(1, 0, 12'h030, 2'd2, 0, 0, 64'h0);
    set_m1(1, 0, 12'h038, 2'd2, 0, 1, 64'h0);
    lk_pat = '{0, 1, 1, 1, 1, 1, 0, 1};
    for (int k = 0; k < 8; k++) begin
      apply_stimulus();
      check_output($sformatf("lock_gnt_%0d", k), 64'(gnt_seen), 64'(lk_pat[k]));
    end

    // Misaligned write must not touch memory.
    do_reset();
    set_m1(1, 1, 12'h004, 2'd2, 0, 0, 64'hCAFEBABE);
    apply_stimulus();
    set_m1(1, 1, 12'h006, 2'd2, 0, 0, 64'h12345678);
    apply_stimulus();
    check_output("mis_gnt", 64'(gnt_seen), 64'd1);
    check_output("mis_cs", cs_seen, 1'b0);
    check_output("mis_rvalid", m1_rvalid, 1'b1);
    check_output("mis_err", m1_err, 1'b1);
    check_output("mis_rdata", m1_rdata, 64'h0);
    set_m1(1, 0, 12'h004, 2'd2, 1, 0, 64'h0);
    apply_stimulus();
    check_output("mis_rd_err", m1_err, 1'b0);
    check_output("mis_rd_data", m1_rdata, 64'hCAFEBABE);
    set_m1(0, 0, 12'h0, 2'd0, 0, 0, 64'h0);
    apply_stimulus();

    // Random traffic; requests stay stable until the model says they were granted.
    do_reset();
    model_win = -1;
    for (int c = 0; c < 600; c++) begin
      if (!m0_req || model_win == 0) begin
        rand_fields(we, addr, size, uns, lock, wdata);
        set_m0($urandom_range(0, 3) != 0, we, addr, size, uns, lock, wdata);
      end
      if (!m1_req || model_win == 1) begin
        rand_fields(we, addr, size, uns, lock, wdata);
        set_m1($urandom_range(0, 3) != 0, we, addr, size, uns, lock, wdata);
      end
      apply_stimulus();
    end

    // Asynchronous reset while a response is showing.
    do_reset();
    set_m0(1, 0, 12'h010, 2'd3, 0, 0, 64'h0);
    apply_stimulus();
    check_output("pre_rst_rvalid", m0_rvalid, 1'b1);
    set_m0(0, 0, 12'h0, 2'd0, 0, 0, 64'h0);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("rst_async_rvalid", m0_rvalid, 1'b0);
    check_output("rst_async_rdata", m0_rdata, 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_m0(1, 0, 12'h020, 2'd2, 0, 0, 64'h0);
    set_m1(1, 0, 12'h028, 2'd2, 0, 0, 64'h0);
    apply_stimulus();
    check_output("post_rst_gnt", 64'(gnt_seen), 64'd0);
    set_m0(0, 0, 12'h0, 2'd0, 0, 0, 64'h0);
    set_m1(0, 0, 12'h0, 2'd0, 0, 0, 64'h0);
    apply_stimulus();
    apply_stimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
